lsu_dmem_master: RTL and testbench

- Load/store initiator between the multi-cycle CPU datapath and the data memory.
- Accepts one CPU memory request at a time and checks alignment (and optionally address range).
- Drives the data memory's ena/wena/w_cs/r_cs/addr/data_in, captures the memory's right-justified read data, and returns a sign- or zero-extended 32-bit result.
- A single-cycle response pulse lets the control FSM advance to write-back.

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/lsu_dmem_master_if.sv | 43 ++++
 rtl/lsu_load_ext.sv | 28 ++
 rtl/lsu_dmem_master.sv | 171 +++++++++++++++++
 tb/tb_lsu_dmem_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit data-memory master.
//   op_t     : CPU memory operation encoding (LW..SB)
//   width_t  : data-memory access width code driven on dm_w_cs / dm_r_cs
//   fault_t  : response fault code
//   state_t  : request FSM state
// Helper functions classify an op by width, direction and alignment.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_t;

    // W_NONE is what the width outputs rest at outside an access.
    typedef enum logic [1:0] {
        W_NONE = 2'b00,
        W_WORD = 2'b01,
        W_HALF = 2'b10,
        W_BYTE = 2'b11
    } width_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic width_t op_width(op_t op);
        case (op)
            OP_LW, OP_SW:         return W_WORD;
            OP_LH, OP_LHU, OP_SH: return W_HALF;
            default:              return W_BYTE;
        endcase
    endfunction

    function automatic logic op_is_store(op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Words must sit on a 4-byte boundary, halves on a 2-byte boundary.
    function automatic logic op_misaligned(op_t op, logic [1:0] addr_lo);
        case (op_width(op))
            W_WORD:  return addr_lo != 2'b00;
            W_HALF:  return addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// lsu_dmem_master_if
// Bundles the CPU request/response handshake and the data-memory bus.
//   CPU side   : req_valid, req_ready, req_op[2:0], req_addr[31:0], req_wdata[31:0],
//                resp_valid, resp_rdata[31:0], resp_fault, resp_fault_code[1:0]
//   Memory side: dm_ena, dm_wena, dm_w_cs[1:0], dm_r_cs[1:0], dm_addr[31:0],
//                dm_data_in[31:0], dm_data_out[31:0]
// Modports:
//   master : the LSU (drives ready/response and the memory controls)
//   slave  : the environment (CPU control and data memory)
interface lsu_dmem_master_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_fault_code;

    logic        dm_ena;
    logic        dm_wena;
    logic [1:0]  dm_w_cs;
    logic [1:0]  dm_r_cs;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_in;
    logic [31:0] dm_data_out;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, dm_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code,
               dm_ena, dm_wena, dm_w_cs, dm_r_cs, dm_addr, dm_data_in
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, dm_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code,
               dm_ena, dm_wena, dm_w_cs, dm_r_cs, dm_addr, dm_data_in
    );

endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext
// Turns the right-justified data-memory read word into the architectural
// load result: LW passes through, LH/LB sign-extend, LHU/LBU zero-extend.
// Store ops produce zero.
//   op     in  op_t     operation of the access being completed
//   data   in  32       memory read data, right-justified
//   result out 32       extended load value
module lsu_load_ext
    import lsu_pkg::*;
(
    input  op_t         op,
    input  logic [31:0] data,
    output logic [31:0] result
);

    always_comb begin
        result = 32'h0000_0000;
        case (op)
            OP_LW:   result = data;
            OP_LH:   result = {{16{data[15]}}, data[15:0]};
            OP_LHU:  result = {16'h0000, data[15:0]};
            OP_LB:   result = {{24{data[7]}}, data[7:0]};
            OP_LBU:  result = {24'h00_0000, data[7:0]};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master
// Load/store initiator between the multi-cycle CPU datapath and data memory.
// One request at a time: IDLE accepts and checks it, ISSUE drives the memory
// for exactly one cycle, DONE presents a one-cycle response pulse.
// Faulted requests skip ISSUE and never touch the memory.
//
// Parameters:
//   BASE_ADDR   byte address of data-memory word 0
//   DEPTH_WORDS number of 32-bit words in data memory
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  lsu_dmem_master_if.master (CPU handshake + data-memory bus)
// Build option:
//   LSU_RANGE_CHECK_EN  when defined, requests whose offset from BASE_ADDR
//                       falls outside the memory fault with code 10.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024
)
(
    input  logic               clk,
    input  logic               rst,
    lsu_dmem_master_if.master  bus
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_ON = 1'b1;
`else
    localparam bit RANGE_CHECK_ON = 1'b0;
`endif

    // One bit wider than an address so a 4 GiB memory still compares correctly.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    state_t      state_q;
    state_t      state_d;

    op_t         op_q;
    fault_t      fault_q;
    logic [31:0] rdata_q;

    logic        dm_ena_q;
    logic        dm_wena_q;
    width_t      dm_w_cs_q;
    width_t      dm_r_cs_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_data_in_q;

    op_t         req_op_in;
    width_t      req_width;
    logic        req_store;
    logic [31:0] req_offset;
    logic        req_out_of_range;
    fault_t      req_fault;
    logic [31:0] load_result;

    // Classify the incoming request. The offset subtraction wraps modulo 2^32,
    // so addresses below BASE_ADDR look huge and land out of range.
    // Misalignment is checked first so it wins when both faults apply.
    always_comb begin
        req_op_in        = op_t'(bus.req_op);
        req_width        = op_width(req_op_in);
        req_store        = op_is_store(req_op_in);
        req_offset       = bus.req_addr - BASE_ADDR;
        req_out_of_range = ({1'b0, req_offset} >= SPAN_BYTES);
        req_fault        = FAULT_NONE;
        if (op_misaligned(req_op_in, bus.req_addr[1:0])) begin
            req_fault = FAULT_MISALIGN;
        end else if (RANGE_CHECK_ON && req_out_of_range) begin
            req_fault = FAULT_RANGE;
        end
    end

    lsu_load_ext u_load_ext (
        .op     (op_q),
        .data   (bus.dm_data_out),
        .result (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Faults jump straight to DONE; good requests spend one cycle in ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = (req_fault != FAULT_NONE) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture and memory drive. The dm_* registers are loaded on the
    // accepting edge so they are valid for the whole ISSUE cycle, and the
    // strobes fall back to zero on the edge that ends ISSUE. Async reset drops
    // the strobes immediately, abandoning a store whose write edge is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= OP_LW;
            fault_q      <= FAULT_NONE;
            rdata_q      <= 32'h0000_0000;
            dm_ena_q     <= 1'b0;
            dm_wena_q    <= 1'b0;
            dm_w_cs_q    <= W_NONE;
            dm_r_cs_q    <= W_NONE;
            dm_addr_q    <= 32'h0000_0000;
            dm_data_in_q <= 32'h0000_0000;
        end else begin
            dm_ena_q  <= 1'b0;
            dm_wena_q <= 1'b0;
            dm_w_cs_q <= W_NONE;
            dm_r_cs_q <= W_NONE;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= req_op_in;
                        fault_q <= req_fault;
                        rdata_q <= 32'h0000_0000;
                        if (req_fault == FAULT_NONE) begin
                            dm_ena_q  <= 1'b1;
                            dm_addr_q <= bus.req_addr;
                            if (req_store) begin
                                dm_wena_q    <= 1'b1;
                                dm_w_cs_q    <= req_width;
                                dm_data_in_q <= bus.req_wdata;
                            end else begin
                                dm_r_cs_q    <= req_width;
                                dm_data_in_q <= 32'h0000_0000;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    // Memory read is combinational, so the data is ready now.
                    if (!op_is_store(op_q)) begin
                        rdata_q <= load_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready       = (state_q == ST_IDLE);
    assign bus.resp_valid      = (state_q == ST_DONE);
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_fault      = (fault_q != FAULT_NONE);
    assign bus.resp_fault_code = fault_q;

    assign bus.dm_ena          = dm_ena_q;
    assign bus.dm_wena         = dm_wena_q;
    assign bus.dm_w_cs         = dm_w_cs_q;
    assign bus.dm_r_cs         = dm_r_cs_q;
    assign bus.dm_addr         = dm_addr_q;
    assign bus.dm_data_in      = dm_data_in_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master
// Drives lsu_dmem_master with directed and random requests against a little-
// endian byte memory, and checks every cycle against a request-level model.
// Honours LSU_RANGE_CHECK_EN the same way the design does.
module tb_lsu_dmem_master;
    import lsu_pkg::*;

    localparam logic [31:0] BASE     = 32'h1001_0000;
    localparam int          ENV_SIZE = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_dmem_master_if bus ();

    lsu_dmem_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Environment memory: covers offsets 0..8191 above BASE, anything else
    // reads as zero and ignores writes.
    logic [7:0]  env_mem [0:ENV_SIZE-1];
    logic [31:0] env_roff;
    logic [31:0] env_woff;
    int          env_ridx;
    int          env_widx;
    int          wr_count = 0;

    always_comb begin
        env_roff        = bus.dm_addr - BASE;
        env_ridx        = int'(env_roff[12:0]);
        bus.dm_data_out = 32'h0;
        if (env_roff < 32'(ENV_SIZE)) begin
            case (bus.dm_r_cs)
                2'b01: bus.dm_data_out = {env_mem[env_ridx+3], env_mem[env_ridx+2],
                                          env_mem[env_ridx+1], env_mem[env_ridx]};
                2'b10: bus.dm_data_out = {16'h0, env_mem[env_ridx+1], env_mem[env_ridx]};
                2'b11: bus.dm_data_out = {24'h0, env_mem[env_ridx]};
                default: bus.dm_data_out = 32'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.dm_ena && bus.dm_wena) begin
            env_woff = bus.dm_addr - BASE;
            env_widx = int'(env_woff[12:0]);
            wr_count = wr_count + 1;
            if (env_woff < 32'(ENV_SIZE)) begin
                case (bus.dm_w_cs)
                    2'b01: begin
                        env_mem[env_widx]   <= bus.dm_data_in[7:0];
                        env_mem[env_widx+1] <= bus.dm_data_in[15:8];
                        env_mem[env_widx+2] <= bus.dm_data_in[23:16];
                        env_mem[env_widx+3] <= bus.dm_data_in[31:24];
                    end
                    2'b10: begin
                        env_mem[env_widx]   <= bus.dm_data_in[7:0];
                        env_mem[env_widx+1] <= bus.dm_data_in[15:8];
                    end
                    2'b11: env_mem[env_widx] <= bus.dm_data_in[7:0];
                    default: begin
                    end
                endcase
            end
        end
    end

    // ---------------- Reference model ----------------
    logic [7:0] shadow [logic [31:0]];

    int          cyc       = 0;
    int          idle_from = 0;
    int          issue_cyc = -1;
    int          done_cyc  = -1;
    logic        exp_store;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_width;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_code;
    logic        pend_store = 1'b0;
    int          pend_size;
    logic        check_en = 1'b0;

    function automatic logic [7:0] shadow_rd(logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return 8'h00;
    endfunction

    function automatic int op_bytes(logic [2:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        idle_from  = cyc;
        issue_cyc  = -1;
        done_cyc   = -1;
        pend_store = 1'b0;
    endtask

    task automatic model_accept(logic [2:0] op, logic [31:0] addr, logic [31:0] wdata);
        int          size;
        logic [31:0] val;
        size = op_bytes(op);
        exp_code = 2'b00;
        if ((addr % 32'(size)) != 0) begin
            exp_code = 2'b01;
        end
`ifdef LSU_RANGE_CHECK_EN
        else if ((addr - BASE) >= 32'd4096) begin
            exp_code = 2'b10;
        end
`endif
        exp_rdata = 32'h0;
        if (exp_code != 2'b00) begin
            done_cyc  = cyc;
            idle_from = cyc + 1;
        end else begin
            issue_cyc = cyc;
            done_cyc  = cyc + 1;
            idle_from = cyc + 2;
            exp_store = (op >= 3'd5);
            exp_addr  = addr;
            exp_wdata = wdata;
            exp_width = (size == 4) ? 2'b01 : (size == 2) ? 2'b10 : 2'b11;
            if (exp_store) begin
                pend_store = 1'b1;
                pend_size  = size;
            end else begin
                val = 32'h0;
                for (int b = 0; b < size; b++) begin
                    val = val | (32'(shadow_rd(addr + 32'(b))) << (8 * b));
                end
                if ((op == OP_LH || op == OP_LB) && val[8*size-1]) begin
                    val = val | (32'hFFFF_FFFF << (8 * size));
                end
                exp_rdata = val;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            model_reset();
        end else begin
            if (pend_store && (cyc - 1 == issue_cyc)) begin
                for (int b = 0; b < pend_size; b++) begin
                    shadow[exp_addr + 32'(b)] = exp_wdata[8*b +: 8];
                end
                pend_store = 1'b0;
            end
            if (bus.req_valid && (cyc - 1 >= idle_from)) begin
                model_accept(bus.req_op, bus.req_addr, bus.req_wdata);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt = total_cnt + 1;
        if (act === req) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("[TB] FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("req_ready", 32'(bus.req_ready), 32'(cyc >= idle_from));
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(cyc == done_cyc));
            if (cyc == issue_cyc) begin
                checkOutput("dm_ena", 32'(bus.dm_ena), 32'd1);
                checkOutput("dm_wena", 32'(bus.dm_wena), 32'(exp_store));
                checkOutput("dm_addr", bus.dm_addr, exp_addr);
                if (exp_store) begin
                    checkOutput("dm_w_cs", 32'(bus.dm_w_cs), 32'(exp_width));
                    checkOutput("dm_data_in", bus.dm_data_in, exp_wdata);
                end else begin
                    checkOutput("dm_r_cs", 32'(bus.dm_r_cs), 32'(exp_width));
                end
            end else begin
                checkOutput("dm_ena_idle", 32'(bus.dm_ena), 32'd0);
                checkOutput("dm_wena_idle", 32'(bus.dm_wena), 32'd0);
            end
            if (cyc == done_cyc) begin
                checkOutput("resp_rdata", bus.resp_rdata, exp_rdata);
                checkOutput("resp_fault_code", 32'(bus.resp_fault_code), 32'(exp_code));
                checkOutput("resp_fault", 32'(bus.resp_fault), 32'(exp_code != 2'b00));
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic waitReady();
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] rdata, output logic [1:0] code,
                                 output logic ena_seen, output logic wena1, output logic [1:0] wcs1);
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat      = 1;
        ena_seen = bus.dm_ena;
        wena1    = bus.dm_wena;
        wcs1     = bus.dm_w_cs;
        while (!bus.resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
            ena_seen = ena_seen | bus.dm_ena;
        end
        checkOutput("resp_seen", 32'(bus.resp_valid), 32'd1);
        rdata = bus.resp_rdata;
        code  = bus.resp_fault_code;
    endtask

    int          lat;
    logic [31:0] rdata;
    logic [1:0]  code;
    logic        ena_seen;
    logic        wena1;
    logic [1:0]  wcs1;

    initial begin
        logic [2:0]  op;
        logic [31:0] off;
        logic [31:0] a;
        int          r;
        int          saved_wr;

        for (int i = 0; i < ENV_SIZE; i++) env_mem[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;

        #1;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("rst_resp_fault", {30'h0, bus.resp_fault_code} | 32'(bus.resp_fault), 32'h0);
        checkOutput("rst_dm_strobes", {28'h0, bus.dm_ena, bus.dm_wena, 2'b00} | 32'(bus.dm_w_cs) | 32'(bus.dm_r_cs), 32'h0);
        checkOutput("rst_dm_addr", bus.dm_addr, 32'h0);
        checkOutput("rst_dm_data_in", bus.dm_data_in, 32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        $display("[TB] directed sequence");
        applyStimulus(OP_SW, BASE + 32'h4, 32'hDEAD_BEEF, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("sw_latency", 32'(lat), 32'd2);
        checkOutput("sw_ena", 32'(ena_seen), 32'd1);
        checkOutput("sw_wena", 32'(wena1), 32'd1);
        checkOutput("sw_w_cs", 32'(wcs1), 32'h1);
        checkOutput("sw_code", 32'(code), 32'h0);
        checkOutput("sw_rdata", rdata, 32'h0);

        applyStimulus(OP_LB, BASE + 32'h4, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("lb_rdata", rdata, 32'hFFFF_FFEF);
        checkOutput("lb_latency", 32'(lat), 32'd2);
        applyStimulus(OP_LBU, BASE + 32'h4, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("lbu_rdata", rdata, 32'h0000_00EF);
        applyStimulus(OP_LH, BASE + 32'h6, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("lh_rdata", rdata, 32'hFFFF_DEAD);
        applyStimulus(OP_LHU, BASE + 32'h6, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("lhu_rdata", rdata, 32'h0000_DEAD);
        applyStimulus(OP_LW, BASE + 32'h4, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("lw_rdata", rdata, 32'hDEAD_BEEF);

        applyStimulus(OP_LW, BASE + 32'h2, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("misalign_latency", 32'(lat), 32'd1);
        checkOutput("misalign_code", 32'(code), 32'h1);
        checkOutput("misalign_ena", 32'(ena_seen), 32'd0);
        checkOutput("misalign_rdata", rdata, 32'h0);

        applyStimulus(OP_LW, BASE + 32'h1000, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
`ifdef LSU_RANGE_CHECK_EN
        checkOutput("range_code", 32'(code), 32'h2);
        checkOutput("range_ena", 32'(ena_seen), 32'd0);
        checkOutput("range_latency", 32'(lat), 32'd1);
`else
        checkOutput("range_code", 32'(code), 32'h0);
        checkOutput("range_ena", 32'(ena_seen), 32'd1);
        checkOutput("range_latency", 32'(lat), 32'd2);
`endif

        $display("[TB] random sequence");
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            r  = int'($urandom_range(0, 99));
            op = 3'($urandom_range(0, 7));
            if (r < 60) begin
                off = 32'($urandom_range(0, 63));
            end else if (r < 80) begin
                off = 32'($urandom_range(0, 4095));
            end else if (r < 92) begin
                off = 32'($urandom_range(4096, 8188));
            end else begin
                off = 32'h0 - 32'($urandom_range(1, 64));
                op  = 3'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 2) != 0) begin
                off = off & ~(32'(op_bytes(op)) - 32'd1);
            end
            bus.req_op    = op;
            bus.req_addr  = BASE + off;
            bus.req_wdata = $urandom;
            bus.req_valid = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;

        $display("[TB] reset during store issue");
        a = BASE + 32'h20;
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SB;
        bus.req_addr  = a;
        bus.req_wdata = {24'h0, ~shadow_rd(a)};
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        checkOutput("pre_rst_wena", 32'(bus.dm_wena), 32'd1);
        saved_wr = wr_count;
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput("mid_rst_wena", 32'(bus.dm_wena), 32'd0);
        checkOutput("mid_rst_ena", 32'(bus.dm_ena), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abandoned_write_count", 32'(wr_count), 32'(saved_wr));
        checkOutput("abandoned_byte", 32'(env_mem[32]), 32'(shadow_rd(a)));
        checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);
        repeat (4) @(negedge clk);

        applyStimulus(OP_LBU, a, 32'h0, lat, rdata, code, ena_seen, wena1, wcs1);
        checkOutput("post_rst_load", rdata, 32'(shadow_rd(a)));

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
